// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Define FIFO_ARB_BURST_EN to let an owner hold the grant for up to MAX_BURST transfers.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             fifo_wr_en,
    output logic [DATA_WIDTH-1:0]            fifo_data,
    input  logic                             fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               lock;
    logic               owner_valid;
    logic               transfer;
    logic               last_beat;
    logic               release_grant;
    logic [PTR_W-1:0]   rr_wrap;

    // First valid index at or after start, searching upward modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] pick(input logic [NUM_REQ-1:0] v,
                                              input logic [PTR_W-1:0]   start);
        logic [PTR_W-1:0] res;
        logic             found;
        int               idx;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(start) + i) % NUM_REQ;
            if (!found && v[idx]) begin
                res   = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign lock        = (state_q == ST_LOCK);
    assign owner_valid = req_valid[owner_q];
    assign transfer    = lock && owner_valid && !fifo_full;
    assign rr_wrap     = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    assign last_beat = transfer && ((int'(beat_cnt_q) + 1) == MAX_BURST);
`else
    logic unused_cfg;

    assign unused_cfg = (MAX_BURST != 0);
    assign last_beat  = transfer;
`endif

    assign release_grant = lock && (!owner_valid || last_beat);

    always_comb begin
        req_ready = '0;
        if (lock && !fifo_full) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    assign fifo_wr_en = transfer;
    assign fifo_data  = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id   = owner_q;
    assign busy       = busy_q;

    // On release the pointer moves past the old owner and, if anyone is still
    // asking, the next owner is chosen in the same cycle so handover has no bubble.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
`ifdef FIFO_ARB_BURST_EN
        beat_cnt_d = beat_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FIFO_ARB_BURST_EN
                beat_cnt_d = '0;
`endif
                if (|req_valid) begin
                    state_d = ST_LOCK;
                    owner_d = pick(req_valid, rr_ptr_q);
                end
            end
            ST_LOCK: begin
                if (release_grant) begin
                    rr_ptr_d = rr_wrap;
`ifdef FIFO_ARB_BURST_EN
                    beat_cnt_d = '0;
`endif
                    if (|req_valid) begin
                        owner_d = pick(req_valid, rr_wrap);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef FIFO_ARB_BURST_EN
                else if (transfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a behavioural grant model queues expected
// per-cycle outputs and writes; a monitor compares them against the DUT.
module tb_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data;
    logic              fifo_full;
    logic [1:0]        grant_id;
    logic              busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ready;
        logic         wr;
        logic [DW-1:0] data;
        int           id;
        logic         busy;
    } status_t;

    typedef struct {
        logic [DW-1:0] data;
        int            id;
    } write_t;

    status_t status_q[$];
    write_t  write_q[$];

    int vectors = 0;
    int miscompares = 0;

    // Model state: who holds the grant, where the rotation starts, beats taken.
    int m_busy  = 0;
    int m_owner = 0;
    int m_rr    = 0;
    int m_beats = 0;

    function automatic int first_valid(input logic [N-1:0] v, input int start);
        for (int i = 0; i < N; i++) begin
            if (v[(start + i) % N]) return (start + i) % N;
        end
        return start;
    endfunction

    function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] d, input int idx);
        return d[idx*DW +: DW];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, queues what the DUT must show, then advances the model.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                                 input logic full, input logic r);
        status_t s;
        write_t  w;
        int      wr;
        int      done;
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        fifo_full = full;
        rst       = r;
        if (r) begin
            m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0;
        end
        wr = (m_busy != 0 && v[m_owner] && !full) ? 1 : 0;
        s.ready = (m_busy != 0 && !full) ? N'(1 << m_owner) : '0;
        s.wr    = (wr != 0);
        s.data  = slice(d, m_owner);
        s.id    = m_owner;
        s.busy  = (m_busy != 0);
        status_q.push_back(s);
        if (wr != 0) begin
            w.data = slice(d, m_owner);
            w.id   = m_owner;
            write_q.push_back(w);
        end
        if (r) begin
            // stays in reset
        end else if (m_busy == 0) begin
            if (v != 0) begin
                m_busy  = 1;
                m_owner = first_valid(v, m_rr);
                m_beats = 0;
            end
        end else begin
            m_beats = m_beats + wr;
            done = (!v[m_owner]) || (wr != 0 && (!BURST || m_beats == MAXB));
            if (done) begin
                m_rr    = (m_owner + 1) % N;
                m_beats = 0;
                if (v != 0) m_owner = first_valid(v, m_rr);
                else        m_busy  = 0;
            end
        end
    endtask

    // Monitor: one status entry per cycle, one write entry per observed write.
    initial begin
        status_t s;
        write_t  w;
        forever begin
            @(negedge clk);
            if (status_q.size() != 0) begin
                s = status_q.pop_front();
                checkOutput("req_ready", 32'(req_ready), 32'(s.ready));
                checkOutput("fifo_wr_en", 32'(fifo_wr_en), 32'(s.wr));
                checkOutput("fifo_data", 32'(fifo_data), 32'(s.data));
                checkOutput("grant_id", 32'(grant_id), 32'(s.id));
                checkOutput("busy", 32'(busy), 32'(s.busy));
            end
            if (fifo_wr_en === 1'b1) begin
                if (write_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(1), 32'(0));
                end else begin
                    w = write_q.pop_front();
                    checkOutput("write_data", 32'(fifo_data), 32'(w.data));
                    checkOutput("write_id", 32'(grant_id), 32'(w.id));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    initial begin
        logic [N*DW-1:0] d;
        logic [N-1:0]    v;
        logic            f;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        applyStimulus('0, rand_data(), 1'b0, 1'b1);
        applyStimulus(4'b1111, rand_data(), 1'b0, 1'b1);
        applyStimulus('0, rand_data(), 1'b0, 1'b0);

        // Single producer 0 with 0xA1
        d = rand_data();
        d[7:0] = 8'hA1;
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, d, 1'b0, 1'b0);
        applyStimulus('0, d, 1'b0, 1'b0);
        applyStimulus('0, d, 1'b0, 1'b0);

        // Everyone asking: rotation 0,1,2,3 and wrap
        for (int i = 0; i < 14; i++) applyStimulus(4'b1111, rand_data(), 1'b0, 1'b0);
        applyStimulus('0, rand_data(), 1'b0, 1'b0);

        // Two producers sharing
        for (int i = 0; i < 12; i++) applyStimulus(4'b0110, rand_data(), 1'b0, 1'b0);
        applyStimulus('0, rand_data(), 1'b0, 1'b0);

        // FIFO full for 5 cycles mid-grant
        for (int i = 0; i < 2; i++) applyStimulus(4'b0001, rand_data(), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b0001, rand_data(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b0001, rand_data(), 1'b0, 1'b0);
        applyStimulus('0, rand_data(), 1'b0, 1'b0);

        // Owner 2 drops valid while 3 waits
        for (int i = 0; i < 2; i++) applyStimulus(4'b0100, rand_data(), 1'b0, 1'b0);
        applyStimulus(4'b1100, rand_data(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'b1000, rand_data(), 1'b0, 1'b0);

        // Reset during a grant held by 3, then lowest valid wins
        applyStimulus(4'b1000, rand_data(), 1'b0, 1'b1);
        applyStimulus(4'b1010, rand_data(), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(4'b1010, rand_data(), 1'b0, 1'b0);

        // Randomised traffic with sticky valids, stalls and rare resets
        v = '0;
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) v[b] = ~v[b];
            end
            f = ($urandom_range(4) == 0);
            applyStimulus(v, rand_data(), f, ($urandom_range(99) == 0));
        end
        applyStimulus('0, rand_data(), 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        checkOutput("status_queue_drained", 32'(status_q.size()), 32'(0));
        checkOutput("write_queue_drained", 32'(write_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
